traffic_sensor_frontend: RTL

Sensor-side counterpart to the traffic light controller: it conditions raw vehicle-loop and exit-detector signals for streets A and B and produces the controller's traffic-present inputs `Ta`/`Tb`. It consumes the controller's light outputs to decide when departures are legal and to flag illegal light combinations. It sits between the roadside detectors and the controller, in the same clock domain.

---
 rtl/traffic_sensor_frontend.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/traffic_sensor_frontend.sv
// traffic_sensor_frontend
//   Conditions the raw roadside detectors for streets A and B and produces the
//   traffic-present inputs for the traffic light controller.
//   - Each raw detector is synchronized (2 flops), then debounced: the level
//     only changes after DEB_CYCLES consecutive cycles of disagreement.
//   - A debounced 0->1 on car_x is an arrival, on exit_x a departure.
//   - Departures only count while that street's light is green or yellow.
//   - Per-street saturating vehicle counters drive registered Ta/Tb.
//   - light_fault is a sticky flag for illegal light combinations.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   car_a, car_b           : raw arrival loop detectors (asynchronous)
//   exit_a, exit_b         : raw stop-line exit detectors (asynchronous)
//   La1, La0, Lb1, Lb0     : controller light codes {x1,x0}: 00 G, 01 Y, 10 R, 11 illegal
//   Ta, Tb                 : traffic present on street A / B
//   count_a, count_b       : vehicles waiting on A / B
//   light_fault            : sticky illegal-light flag
module traffic_sensor_frontend #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_a,
  input  logic             car_b,
  input  logic             exit_a,
  input  logic             exit_b,
  input  logic             La1,
  input  logic             La0,
  input  logic             Lb1,
  input  logic             Lb0,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             light_fault
);

  localparam int               DC_W    = $clog2(DEB_CYCLES);
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Channel order: 0 car_a, 1 car_b, 2 exit_a, 3 exit_b
  logic [3:0] raw_in;
  logic [3:0] deb_rise;

  assign raw_in = {exit_b, exit_a, car_b, car_a};

  genvar gi;

  // Synchronizer + debouncer per detector channel
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic            meta_q;
      logic            sync_q;
      logic            deb_q;
      logic            deb_d;
      logic [DC_W-1:0] dc_q;
      logic [DC_W-1:0] dc_d;

      // dc counts consecutive cycles where the synchronized level disagrees
      // with the debounced level; any agreement restarts the count.
      always_comb begin
        deb_d = deb_q;
        dc_d  = '0;
        if (sync_q != deb_q) begin
          if (dc_q == DC_LAST) begin
            deb_d = sync_q;
          end else begin
            dc_d = dc_q + DC_W'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
          deb_q  <= 1'b0;
          dc_q   <= '0;
        end else begin
          meta_q <= raw_in[gi];
          sync_q <= meta_q;
          deb_q  <= deb_d;
          dc_q   <= dc_d;
        end
      end

      // Event fires in the cycle the debounced level is about to rise, so the
      // counters update on the same edge as deb.
      assign deb_rise[gi] = deb_d & ~deb_q;
    end
  endgenerate

  // Departure allowed on green (00) or yellow (01) only
  logic [1:0]       depart_ok;
  logic [CNT_W-1:0] count_vec [2];
  logic [1:0]       t_vec;

  assign depart_ok = {~Lb1, ~La1};

  // Per-street vehicle counter and traffic-present register
  generate
    for (gi = 0; gi < 2; gi++) begin : g_street
      logic             arrive;
      logic             depart;
      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;
      logic             t_q;
      logic             t_d;

      assign arrive = deb_rise[gi];
      assign depart = deb_rise[gi+2] & depart_ok[gi];

      always_comb begin
        count_d = count_q;
        if (arrive && !depart) begin
          if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
        end else if (depart && !arrive) begin
          if (count_q != '0) count_d = count_q - CNT_W'(1);
        end
        // Registered from the next count so T tracks count with no extra lag
        t_d = |count_d;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_q <= '0;
          t_q     <= 1'b0;
        end else begin
          count_q <= count_d;
          t_q     <= t_d;
        end
      end

      assign count_vec[gi] = count_q;
      assign t_vec[gi]     = t_q;
    end
  endgenerate

  // Sticky light fault: either code illegal, or neither street red
  logic illegal_lights;
  logic light_fault_q;
  logic light_fault_d;

  always_comb begin
    illegal_lights = (La1 & La0) | (Lb1 & Lb0) | (~La1 & ~Lb1);
    light_fault_d  = light_fault_q | illegal_lights;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      light_fault_q <= 1'b0;
    end else begin
      light_fault_q <= light_fault_d;
    end
  end

  assign count_a     = count_vec[0];
  assign count_b     = count_vec[1];
  assign Ta          = t_vec[0];
  assign Tb          = t_vec[1];
  assign light_fault = light_fault_q;

endmodule
